booth2_pp_accumulator: RTL and testbench

- Sequential stage directly downstream of the Booth-2 partial-product generator for the 16x16 signed multiplier.
- Captures the 8 raw partial products PP1..PP8. Each is 18-bit two's complement, not shifted and not sign-extended.
- Accumulates one partial product per clock into a 32-bit signed product, then presents the result with a valid/ready handshake.
- Serves as the low-area, multi-cycle alternative to the Wallace-tree reduction path.

---
 rtl/booth2_pp_accumulator.sv | 100 ++++++++++
 tb/tb_booth2_pp_accumulator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth2_pp_accumulator.sv
// Purpose: sums the 8 raw Booth-2 partial products of a 16x16 signed multiply, one per clock, into a 32-bit product.
// Latency: out_valid rises 8 cycles after the accept edge; one operation per 10 cycles at best.
// Backpressure: in_ready only in IDLE; product is held with out_valid until out_ready completes the handshake.
module booth2_pp_accumulator #(
    parameter int PP_W   = 18,
    parameter int PROD_W = 32,
    parameter int NUM_PP = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PP_W-1:0]   pp1,
    input  logic [PP_W-1:0]   pp2,
    input  logic [PP_W-1:0]   pp3,
    input  logic [PP_W-1:0]   pp4,
    input  logic [PP_W-1:0]   pp5,
    input  logic [PP_W-1:0]   pp6,
    input  logic [PP_W-1:0]   pp7,
    input  logic [PP_W-1:0]   pp8,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    localparam int CNT_W = $clog2(NUM_PP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state;
    logic [NUM_PP-1:0][PP_W-1:0]  bank;
    logic [CNT_W-1:0]             cnt;
    logic [PROD_W-1:0]            acc;

    logic [PP_W-1:0]              pp_sel;
    logic [PROD_W-1:0]            pp_ext;
    logic [CNT_W:0]               shamt;
    logic [PROD_W-1:0]            term;
    logic [PROD_W-1:0]            sum;

    assign in_ready = (state == IDLE);
    assign busy     = (state == ACC);

    // Weight the current partial product: sign-extend from bit 17, shift by 2*cnt, add to the running sum (mod 2^32).
    always_comb begin
        pp_sel = bank[cnt];
        pp_ext = {{(PROD_W-PP_W){pp_sel[PP_W-1]}}, pp_sel};
        shamt  = {cnt, 1'b0};
        term   = pp_ext << shamt;
        sum    = acc + term;
    end

    // Control FSM with datapath: capture bank on accept, accumulate for NUM_PP cycles, hold result until taken.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            bank      <= '0;
            cnt       <= '0;
            acc       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bank  <= {pp8, pp7, pp6, pp5, pp4, pp3, pp2, pp1};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_PP-1)) begin
                        product   <= sum;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth2_pp_accumulator.sv
// Purpose: directed and model-based checks of booth2_pp_accumulator against signed A*B.
// Latency: expects out_valid exactly 8 edges after the accept edge.
// Backpressure: holds out_ready low in DONE and verifies product/handshake stability.
module tb_booth2_pp_accumulator;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    logic [7:0][17:0] pps;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    assign pp1 = pps[0];
    assign pp2 = pps[1];
    assign pp3 = pps[2];
    assign pp4 = pps[3];
    assign pp5 = pps[4];
    assign pp6 = pps[5];
    assign pp7 = pps[6];
    assign pp8 = pps[7];

    booth2_pp_accumulator dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp1       (pp1),
        .pp2       (pp2),
        .pp3       (pp3),
        .pp4       (pp4),
        .pp5       (pp5),
        .pp6       (pp6),
        .pp7       (pp7),
        .pp8       (pp8),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Radix-4 Booth recoding of b, each digit times a, truncated to 18 bits.
    function automatic logic [7:0][17:0] booth(input logic signed [15:0] a, input logic signed [15:0] b);
        logic [7:0][17:0] r;
        logic [16:0]      bx;
        logic [2:0]       trip;
        int               d;
        int               p;
        bx = {b, 1'b0};
        for (int i = 0; i < 8; i++) begin
            trip = bx[2*i+2 -: 3];
            case (trip)
                3'b001, 3'b010: d = 1;
                3'b011:         d = 2;
                3'b100:         d = -2;
                3'b101, 3'b110: d = -1;
                default:        d = 0;
            endcase
            p    = d * int'(a);
            r[i] = p[17:0];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // One full operation with out_ready high: accept, latency, result, handshake.
    task automatic run_op(input string tag, input logic [7:0][17:0] p, input logic [31:0] exp);
        int k;
        pps       = p;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        pps      = '1;
        check({tag, "_busy"}, {30'd0, busy, in_ready}, 32'd2);
        k = 0;
        do begin
            tick;
            k++;
        end while (!out_valid && k < 20);
        check({tag, "_lat"}, 32'(k), 32'd8);
        check({tag, "_prod"}, product, exp);
        tick;
        check({tag, "_drop"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic signed [15:0] a, b;
        logic [31:0]        exp_q[$];
        logic [31:0]        held;
        int                 pushed, pulses, last_acc, k;

        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pps       = '0;
        #12;
        check("rst_hold", {product[30:0], out_valid}, 32'd0);
        #10;
        sys_rst_n = 1'b1;
        tick;
        check("rst_out", {product[29:0], out_valid, busy}, 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);

        // Directed vectors with hand-recoded partial products.
        run_op("a3b5",   {18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h00003, 18'h00003}, 32'h0000000F);
        run_op("am1b2",  {18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h3FFFF, 18'h00002}, 32'hFFFFFFFE);
        run_op("minmin", {18'h10000, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0},     32'h40000000);
        run_op("maxmin", booth(16'sd32767, -16'sd32768), 32'hC0008000);
        run_op("a7b9",   {18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h00007, 18'h3FFF2, 18'h00007}, 32'h0000003F);

        // Random operand pairs against signed multiplication.
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            run_op("rnd", booth(a, b), 32'(int'(a) * int'(b)));
        end

        // Backpressure in DONE for 20 cycles, with a competing in_valid.
        out_ready = 1'b0;
        pps       = booth(16'sd1234, -16'sd567);
        in_valid  = 1'b1;
        tick;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick;
            k++;
        end
        check("bp_lat", 32'(k), 32'd8);
        check("bp_prod", product, 32'hFFF552E2);
        held     = product;
        in_valid = 1'b1;
        pps      = booth(16'sd5, 16'sd5);
        for (int i = 0; i < 20; i++) begin
            tick;
            check("bp_hold", {product[31:2] ^ held[31:2], out_valid, in_ready}, 32'd2);
            check("bp_stable", product, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        check("bp_release", {29'd0, out_valid, in_ready, busy}, 32'd2);
        check("bp_kept", product, 32'hFFF552E2);

        // Reset four cycles into an operation.
        pps      = booth(16'sd100, 16'sd100);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        check("mid_busy", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst", {product[29:0], out_valid, busy}, 32'd0);
        #3;
        sys_rst_n = 1'b1;
        k = 0;
        repeat (12) begin
            tick;
            if (out_valid) k++;
        end
        check("mid_nopulse", 32'(k), 32'd0);
        run_op("post_rst", booth(16'sd7, 16'sd9), 32'h0000003F);

        // Back-to-back with in_valid held and out_ready high.
        pushed    = 0;
        pulses    = 0;
        last_acc  = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (out_valid) begin
                pulses++;
                if (exp_q.size() > 0) check("b2b_prod", product, exp_q.pop_front());
            end
            if (in_ready && pushed < 5) begin
                a    = 16'($urandom);
                b    = 16'($urandom);
                pps  = booth(a, b);
                exp_q.push_back(32'(int'(a) * int'(b)));
                in_valid = 1'b1;
                if (pushed > 0) check("b2b_gap", 32'(cyc - last_acc), 32'd10);
                last_acc = cyc;
                pushed++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
            tick;
        end
        check("b2b_pulses", 32'(pulses), 32'd5);
        check("b2b_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
